// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// keypad_scan_ctrl : 4x4 matrix keypad scanner with whole-matrix debounce and
//                    valid/ack press events. Optional auto-repeat: KEYPAD_REPEAT_EN
// Revision: 1.0
// ============================================================================
module keypad_scan_ctrl #(
   parameter int SCAN_CNT       = 100000,
   parameter int DEBOUNCE_SCANS = 20,
   parameter int REPEAT_DELAY   = 500,
   parameter int REPEAT_PERIOD  = 100
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] row_n,
   input  logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_down,
   output logic       overrun
);

   localparam int               CNT_W    = $clog2(SCAN_CNT);
   localparam int               STB_W    = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_CNT - 1);
   localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);
   // Key identifiers are 5 bits: bit 4 set means "no key", else {row, col}.
   localparam logic [4:0]       KEY_NONE = 5'h10;

   generate
      if (SCAN_CNT < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
      begin : g_param_check
         $error("keypad_scan_ctrl: illegal parameter value");
      end
   endgenerate

   logic [3:0]       col_meta_q, col_meta_d;
   logic [3:0]       col_sync_q, col_sync_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic [1:0]       row_q, row_d;
   logic [3:0]       snap_q [4];
   logic [3:0]       snap_d [4];
   logic             eval_q, eval_d;
   logic [4:0]       prev_cand_q, prev_cand_d;
   logic [STB_W-1:0] stable_q, stable_d;
   logic [4:0]       accepted_q, accepted_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic             key_down_q, key_down_d;
   logic             overrun_q, overrun_d;

   logic [4:0]       cand;
   logic             accept_now;
   logic             press_evt;
   logic             new_evt;
   logic [3:0]       evt_code;
   logic             drop;

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             rep_armed_q, rep_armed_d;
   logic [REP_W-1:0] rep_next;
   logic             rep_evt;
`endif

   // Lowest code wins: scan descending so the last hit is the lowest one.
   always_comb begin
      cand = KEY_NONE;
      for (int r = 3; r >= 0; r--) begin
         for (int c = 3; c >= 0; c--) begin
            if (!snap_q[r][c]) begin
               cand = {1'b0, 2'(r), 2'(c)};
            end
         end
      end
   end

   always_comb begin
      col_meta_d  = col_n;
      col_sync_d  = col_meta_q;
      dwell_d     = dwell_q + CNT_W'(1);
      row_d       = row_q;
      snap_d      = snap_q;
      eval_d      = 1'b0;
      prev_cand_d = prev_cand_q;
      stable_d    = stable_q;
      accepted_d  = accepted_q;
      key_down_d  = key_down_q;
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q;
      overrun_d   = overrun_q;
      accept_now  = 1'b0;
      drop        = 1'b0;

      if (dwell_q == CNT_MAX) begin
         dwell_d       = '0;
         snap_d[row_q] = col_sync_q;
         row_d         = row_q + 2'd1;
         eval_d        = (row_q == 2'd3);
      end

      if (eval_q) begin
         if (cand == prev_cand_q) begin
            if (stable_q != STB_MAX) begin
               stable_d = stable_q + STB_W'(1);
            end
         end else begin
            stable_d    = STB_W'(1);
            prev_cand_d = cand;
         end
         if (stable_d == STB_MAX && cand != accepted_q) begin
            accept_now = 1'b1;
            accepted_d = cand;
            key_down_d = !cand[4];
         end
      end

      press_evt = accept_now && !cand[4];

`ifdef KEYPAD_REPEAT_EN
      rep_cnt_d   = rep_cnt_q;
      rep_armed_d = rep_armed_q;
      rep_next    = rep_cnt_q + REP_W'(1);
      rep_evt     = 1'b0;
      if (eval_q) begin
         if (accept_now) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
         end else if (!accepted_q[4] && cand == accepted_q) begin
            // First repeat after REPEAT_DELAY scans, then every REPEAT_PERIOD.
            if ((!rep_armed_q && rep_next == REP_W'(REPEAT_DELAY)) ||
                ( rep_armed_q && rep_next == REP_W'(REPEAT_PERIOD))) begin
               rep_evt     = 1'b1;
               rep_cnt_d   = '0;
               rep_armed_d = 1'b1;
            end else begin
               rep_cnt_d = rep_next;
            end
         end
      end
      new_evt  = press_evt || rep_evt;
      evt_code = rep_evt ? accepted_q[3:0] : cand[3:0];
`else
      new_evt  = press_evt;
      evt_code = cand[3:0];
`endif

      if (new_evt) begin
         if (key_valid_q && !key_ack) begin
            drop = 1'b1;
         end else begin
            key_valid_d = 1'b1;
            key_code_d  = evt_code;
         end
      end else if (key_ack) begin
         key_valid_d = 1'b0;
      end

      if (drop) begin
         overrun_d = 1'b1;
      end else if (key_ack) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_meta_q  <= 4'hF;
         col_sync_q  <= 4'hF;
         dwell_q     <= '0;
         row_q       <= 2'd0;
         for (int r = 0; r < 4; r++) begin
            snap_q[r] <= 4'hF;   // all columns released
         end
         eval_q      <= 1'b0;
         prev_cand_q <= KEY_NONE;
         stable_q    <= '0;
         accepted_q  <= KEY_NONE;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt_q   <= '0;
         rep_armed_q <= 1'b0;
`endif
      end else begin
         col_meta_q  <= col_meta_d;
         col_sync_q  <= col_sync_d;
         dwell_q     <= dwell_d;
         row_q       <= row_d;
         snap_q      <= snap_d;
         eval_q      <= eval_d;
         prev_cand_q <= prev_cand_d;
         stable_q    <= stable_d;
         accepted_q  <= accepted_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_down_q  <= key_down_d;
         overrun_q   <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt_q   <= rep_cnt_d;
         rep_armed_q <= rep_armed_d;
`endif
      end
   end

   assign row_n     = ~(4'b0001 << row_q);
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_down  = key_down_q;
   assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_keypad_scan_ctrl : keypad matrix model, press-vector table and event
//                       scoreboard for keypad_scan_ctrl
// Revision: 1.0
// ============================================================================
module tb_keypad_scan_ctrl;

   localparam int SCAN_CNT = 4;
   localparam int DEB      = 3;
   localparam int RDLY     = 4;
   localparam int RPER     = 2;
   localparam int SCAN     = 4 * SCAN_CNT;

   logic        clk     = 1'b0;
   logic        rst     = 1'b1;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_ack = 1'b0;
   logic        key_down;
   logic        overrun;

   logic [15:0] keys = 16'h0000;   // bit r*4+c = key (r,c) held
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic [3:0]  exp_q [$];

   typedef struct {
      logic [15:0] keys;
      logic [3:0]  code;
   } press_vec_t;

   press_vec_t  pv [5];
   logic [3:0]  row_tab [4];
   int          t_evt [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   keypad_scan_ctrl #(
      .SCAN_CNT       (SCAN_CNT),
      .DEBOUNCE_SCANS (DEB),
      .REPEAT_DELAY   (RDLY),
      .REPEAT_PERIOD  (RPER)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row_n     (row_n),
      .col_n     (col_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ack   (key_ack),
      .key_down  (key_down),
      .overrun   (overrun)
   );

   always_comb begin
      col_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // A new event is visible when key_valid rises, or stays high across an ack edge.
   always @(posedge clk) begin
      logic v_pre;
      logic a_pre;
      v_pre = key_valid;
      a_pre = key_ack;
      #1;
      if (!rst && key_valid && (!v_pre || a_pre)) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got code %0d, expected no event (t=%0t)", key_code, $time);
         end else begin
            check("event_code", {28'b0, key_code}, {28'b0, exp_q.pop_front()});
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Return at the first cycle of row 0.
   task automatic sync_scan();
      logic [3:0] prev;
      prev = row_n;
      for (int i = 0; i < 2 * SCAN; i++) begin
         @(negedge clk);
         if (prev == 4'b0111 && row_n == 4'b1110) return;
         prev = row_n;
      end
      n_vec++;
      n_err++;
      $display("FAIL sync_timeout: got row_n %b, expected a 0111->1110 transition", row_n);
   endtask

   task automatic wait_valid(input int max, input string name);
      for (int i = 0; i < max && !key_valid; i++) @(negedge clk);
      check(name, {31'b0, key_valid}, 32'd1);
   endtask

   task automatic ack_pulse();
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
   endtask

   task automatic release_all(input string name);
      keys = 16'h0000;
      cycles(5 * SCAN);
      check({name, "_down_released"}, {31'b0, key_down}, 32'd0);
      check({name, "_valid_released"}, {31'b0, key_valid}, 32'd0);
      check({name, "_sb_empty"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      row_tab[0] = 4'b1110;
      row_tab[1] = 4'b1101;
      row_tab[2] = 4'b1011;
      row_tab[3] = 4'b0111;
      pv[0] = '{16'h0200, 4'd9};    // (2,1)
      pv[1] = '{16'h8010, 4'd4};    // (1,0)+(3,3)
      pv[2] = '{16'h0001, 4'd0};    // (0,0)
      pv[3] = '{16'h8000, 4'd15};   // (3,3)
      pv[4] = '{16'h000A, 4'd1};    // (0,1)+(0,3)

      // Reset values and idle row sequencing
      cycles(3);
      check("rst_row_n",     {28'b0, row_n},    32'hE);
      check("rst_key_code",  {28'b0, key_code}, 32'h0);
      check("rst_key_valid", {31'b0, key_valid}, 32'd0);
      check("rst_key_down",  {31'b0, key_down},  32'd0);
      check("rst_overrun",   {31'b0, overrun},   32'd0);
      rst = 1'b0;
      for (int j = 0; j < 200; j++) begin
         check($sformatf("idle_row_n_%0d", j), {28'b0, row_n}, {28'b0, row_tab[(j / SCAN_CNT) % 4]});
         @(negedge clk);
      end
      check("idle_valid", {31'b0, key_valid}, 32'd0);
      check("idle_down",  {31'b0, key_down},  32'd0);
      ack_pulse();
      check("idle_ack_valid",   {31'b0, key_valid}, 32'd0);
      check("idle_ack_overrun", {31'b0, overrun},   32'd0);

      // Clean presses: event exactly at the evaluation of the DEB-th scan
      for (int i = 0; i < 5; i++) begin
         sync_scan();
         keys = pv[i].keys;
         exp_q.push_back(pv[i].code);
         cycles((DEB - 1) * SCAN + SCAN);
         check($sformatf("press%0d_not_early", i), {31'b0, key_valid}, 32'd0);
         cycles(1);
         check($sformatf("press%0d_valid", i), {31'b0, key_valid}, 32'd1);
         check($sformatf("press%0d_code", i),  {28'b0, key_code},  {28'b0, pv[i].code});
         check($sformatf("press%0d_down", i),  {31'b0, key_down},  32'd1);
         ack_pulse();
         check($sformatf("press%0d_acked", i), {31'b0, key_valid}, 32'd0);
         release_all($sformatf("press%0d", i));
      end

      // Bouncing key (0,3), then stable
      sync_scan();
      exp_q.push_back(4'd3);
      repeat (8) begin
         keys[3] = ~keys[3];
         cycles(5);
      end
      check("bounce_no_event", {31'b0, key_valid}, 32'd0);
      keys[3] = 1'b1;
      wait_valid(5 * SCAN, "bounce_event");
      check("bounce_code", {28'b0, key_code}, 32'd3);
      ack_pulse();
      release_all("bounce");

      // Overrun: event 7 arrives while 5 is still pending
      exp_q.push_back(4'd5);
      keys = 16'h0020;
      wait_valid(5 * SCAN, "ovr_first");
      keys = 16'h0000;
      cycles(5 * SCAN);
      check("ovr_release_down", {31'b0, key_down}, 32'd0);
      keys = 16'h0080;
      cycles(5 * SCAN);
      check("ovr_valid",   {31'b0, key_valid}, 32'd1);
      check("ovr_code",    {28'b0, key_code},  32'd5);
      check("ovr_flag",    {31'b0, overrun},   32'd1);
      check("ovr_down",    {31'b0, key_down},  32'd1);
      ack_pulse();
      check("ovr_ack_valid", {31'b0, key_valid}, 32'd0);
      check("ovr_ack_flag",  {31'b0, overrun},   32'd0);
      release_all("ovr");

      // Direct key change 6 -> 10 with ack on the very edge of the new event
      sync_scan();
      keys = 16'h0040;
      exp_q.push_back(4'd6);
      cycles(DEB * SCAN + 1);
      check("chg_first_valid", {31'b0, key_valid}, 32'd1);
      sync_scan();
      keys = 16'h0400;
      exp_q.push_back(4'd10);
      cycles(DEB * SCAN);
      check("chg_hold_code", {28'b0, key_code}, 32'd6);
      key_ack = 1'b1;
      cycles(1);
      key_ack = 1'b0;
      check("chg_valid", {31'b0, key_valid}, 32'd1);
      check("chg_code",  {28'b0, key_code},  32'd10);
      check("chg_ovr",   {31'b0, overrun},   32'd0);
      ack_pulse();
      release_all("chg");

`ifdef KEYPAD_REPEAT_EN
      // Auto-repeat on key 0, every event acknowledged
      for (int k = 0; k < 4; k++) exp_q.push_back(4'd0);
      sync_scan();
      keys = 16'h0001;
      for (int k = 0; k < 4; k++) begin
         wait_valid(8 * SCAN, $sformatf("rep_evt%0d", k));
         t_evt[k] = cyc;
         ack_pulse();
      end
      check("rep_delay",   t_evt[1] - t_evt[0], RDLY * SCAN);
      check("rep_period1", t_evt[2] - t_evt[1], RPER * SCAN);
      check("rep_period2", t_evt[3] - t_evt[2], RPER * SCAN);
      keys = 16'h0000;
      cycles(10 * SCAN);
      check("rep_stop_valid", {31'b0, key_valid}, 32'd0);
      check("rep_stop_sb",    exp_q.size(), 32'd0);
`endif

      // Asynchronous reset while an event is pending
      exp_q.push_back(4'd2);
      keys = 16'h0004;
      wait_valid(5 * SCAN, "arst_pending");
      cycles(SCAN_CNT + 2);
      #2;
      rst = 1'b1;
      #1;
      check("arst_row_n", {28'b0, row_n},    32'hE);
      check("arst_valid", {31'b0, key_valid}, 32'd0);
      check("arst_down",  {31'b0, key_down},  32'd0);
      check("arst_code",  {28'b0, key_code},  32'h0);
      keys = 16'h0000;
      cycles(2);
      rst = 1'b0;
      cycles(SCAN_CNT);
      check("arst_row_resume", {28'b0, row_n}, 32'hD);
      check("arst_sb_empty", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for a 4x4 matrix keypad. It drives rows one at a time, samples the column lines, and debounces whole-matrix scans. It emits press events as a 4-bit key code under a valid/ack handshake. It sits between the board keypad pins and the display/control logic, and replaces one debounce instance per key line with a single sequenced scan engine.

Parameters:
SCAN_CNT, 100000, clk cycles each row is driven (1 ms at 100 MHz); legal minimum is 4
DEBOUNCE_SCANS, 20, consecutive identical full scans required to accept a state change; legal minimum is 1
REPEAT_DELAY, 500, full scans a key must be held before the first auto-repeat (used only with KEYPAD_REPEAT_EN)
REPEAT_PERIOD, 100, full scans between auto-repeats (used only with KEYPAD_REPEAT_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
row_n  out  4  row drive, active-low, exactly one bit low at any time
col_n  in  4  raw column inputs, active-low, pulled up externally, asynchronous
key_code  out  4  code of the accepted key, row*4+col
key_valid  out  1  event pending; held until acknowledged
key_ack  in  1  consumer acknowledge, sampled on clk
key_down  out  1  level: debounced state "some key held"
overrun  out  1  sticky: an event was dropped while key_valid was high

Behaviour:
- Reset values: row_n=4'b1110, key_code=0, key_valid=0, key_down=0, overrun=0. All counters, snapshots, synchronizer flops and candidate state are cleared, with candidate = NONE. Reset mid-scan aborts the scan immediately; a pending event is lost.
- col_n passes through a 2-flop synchronizer (reset value 1111) before any use.
- Dwell counter runs 0..SCAN_CNT-1 per row.
  - On the cycle where the count is SCAN_CNT-1, the synchronized columns are stored into snapshot[row].
  - The row index then advances 0→1→2→3→0, and row_n updates on the same edge.
  - The counter wraps to 0.
- One full scan is 4*SCAN_CNT cycles.
- Scan evaluation happens on the cycle after the row-3 sample:
  - Candidate = lowest code with a low bit, searching row 0 first and col 0 first within a row; NONE if no bit is low.
  - Multiple keys pressed: the lowest code wins.
- Debounce:
  - If the candidate equals the previous scan's candidate, stable_cnt increments, saturating at DEBOUNCE_SCANS.
  - Otherwise stable_cnt=1 and the candidate is stored.
  - Acceptance occurs when stable_cnt reaches DEBOUNCE_SCANS and the candidate differs from the accepted state.
- On acceptance:
  - accepted ← candidate.
  - key_down ← (candidate≠NONE).
  - If the candidate is a key, a press event is raised.
  - Release (→NONE) raises no event.
  - Key A→key B directly (no NONE scan in between) raises a press for B.
- Event handshake:
  - A press event sets key_valid=1 and key_code=code on the same edge as the evaluation.
  - key_code holds stable while key_valid=1.
  - key_valid clears on the edge where key_ack=1.
  - key_ack while key_valid=0 is ignored.
  - A new event with key_valid=1 and key_ack=0 on the same cycle is dropped and sets overrun=1. key_code is unchanged.
  - A new event on the same cycle as key_ack=1 loads the new event: key_valid stays 1 and key_code updates.
  - overrun clears on any edge with key_ack=1 unless a drop occurs on that same edge.
- Latency: a clean press held from scan k is reported at the evaluation of scan k+DEBOUNCE_SCANS-1.

Optional Feature:
Macro KEYPAD_REPEAT_EN.
- When defined: while an accepted key stays held, a scan counter runs.
  - A press event with the same code is raised when the counter reaches REPEAT_DELAY scans after acceptance, then every REPEAT_PERIOD scans after that.
  - Repeat events follow the same handshake and overrun rules as normal presses.
  - The counter clears on release or on a key change.
- When not defined: no repeat logic is present, and the REPEAT_* parameters are unused.

Test Plan:
Bench parameters: SCAN_CNT=4, DEBOUNCE_SCANS=3, so one full scan is 16 cycles. The keypad model pulls col c low when row_n[r]=0 and key (r,c) is held.
- Reset then idle 200 cycles → row_n cycles 1110,1101,1011,0111 with a 4-cycle dwell each; key_valid=0; key_down=0; overrun=0.
- Hold key (2,1) cleanly → key_valid=1 and key_code=9 at the evaluation of the 3rd full scan; key_down=1; after key_ack pulse, key_valid=0.
- Key (0,3) bouncing (toggling every 5 cycles) for 40 cycles, then stable → no event during bounce; exactly one event with code 3 after 3 stable scans.
- Hold keys (1,0) and (3,3) together → single event with code 4; release both → key_down=0 after 3 NONE scans, no event.
- Press 5, no ack, release, press 7 → key_code stays 5 and overrun=1; key_ack → key_valid=0 and overrun=0.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY=4, REPEAT_PERIOD=2, hold key 0 and ack every event → events at acceptance, then 4 scans later, then every 2 scans; release stops the events.
